// File: rtl/lane_deskew.sv
// lane_deskew: two-lane byte deskew that aligns per-lane sync markers through tapped delay lines.
// Optional feature macro LANE_DESKEW_RELOCK_EN: monitor output taps while locked and drop lock on a lone marker.
module lane_deskew #(
  parameter logic [7:0] SYNC_BYTE = 8'h5A,
  parameter int         MAX_SKEW  = 8
) (
  input  logic       enc_clk,
  input  logic       rst,
  input  logic       enable_deskew,
  input  logic [7:0] lane_0_rx,
  input  logic [7:0] lane_1_rx,
  output logic [7:0] lane_0_out,
  output logic [7:0] lane_1_out,
  output logic       lane_valid,
  output logic       deskew_lock,
  output logic       deskew_err,
  output logic [3:0] skew_val,
  output logic       early_lane
);

  typedef enum logic [2:0] {IDLE, SEARCH, WAIT0, WAIT1, LOCKED} state_t;

  localparam logic [4:0] MaxSkew = 5'(MAX_SKEW);

  state_t     state_q, state_d;
  logic [7:0] sr0_q [1:MAX_SKEW];
  logic [7:0] sr1_q [1:MAX_SKEW];
  logic [7:0] tap0 [0:15];
  logic [7:0] tap1 [0:15];
  logic [3:0] d0_q, d0_d, d1_q, d1_d;
  logic [3:0] cnt_q, cnt_d, skew_q, skew_d;
  logic       early_q, early_d, valid_q, valid_d, err_q, err_d;
  logic [7:0] out0_q, out1_q;
  logic [4:0] cnt_inc;
  logic       mark0, mark1, overflow;

  assign mark0    = (lane_0_rx == SYNC_BYTE);
  assign mark1    = (lane_1_rx == SYNC_BYTE);
  assign cnt_inc  = {1'b0, cnt_q} + 5'd1;
  assign overflow = (cnt_inc > MaxSkew);

  // Taps beyond MAX_SKEW never get selected; tie them off so the mux stays a full 16-way.
  assign tap0[0] = lane_0_rx;
  assign tap1[0] = lane_1_rx;
  for (genvar k = 1; k < 16; k++) begin : g_tap
    if (k <= MAX_SKEW) begin : g_used
      assign tap0[k] = sr0_q[k];
      assign tap1[k] = sr1_q[k];
    end else begin : g_unused
      assign tap0[k] = 8'h00;
      assign tap1[k] = 8'h00;
    end
  end

  always_ff @(posedge enc_clk) begin
    if (rst) begin
      for (int k = 1; k <= MAX_SKEW; k++) begin
        sr0_q[k] <= 8'h00;
        sr1_q[k] <= 8'h00;
      end
    end else if (enable_deskew) begin
      sr0_q[1] <= lane_0_rx;
      sr1_q[1] <= lane_1_rx;
      for (int k = 2; k <= MAX_SKEW; k++) begin
        sr0_q[k] <= sr0_q[k-1];
        sr1_q[k] <= sr1_q[k-1];
      end
    end
  end

  always_ff @(posedge enc_clk) begin
    if (rst) begin
      state_q <= IDLE;
      d0_q    <= '0;
      d1_q    <= '0;
      cnt_q   <= '0;
      skew_q  <= '0;
      early_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      out0_q  <= 8'h00;
      out1_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      cnt_q   <= cnt_d;
      skew_q  <= skew_d;
      early_q <= early_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      out0_q  <= tap0[d0_d];
      out1_q  <= tap1[d1_d];
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable_deskew) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   state_d = SEARCH;
        SEARCH: begin
          if (mark0 && mark1) state_d = LOCKED;
          else if (mark0)     state_d = WAIT0;
          else if (mark1)     state_d = WAIT1;
        end
        WAIT0: begin
          if (mark1)         state_d = LOCKED;
          else if (!mark0 && overflow) state_d = SEARCH;
        end
        WAIT1: begin
          if (mark0)         state_d = LOCKED;
          else if (!mark1 && overflow) state_d = SEARCH;
        end
        LOCKED: begin
`ifdef LANE_DESKEW_RELOCK_EN
          if ((tap0[d0_q] == SYNC_BYTE) != (tap1[d1_q] == SYNC_BYTE)) state_d = SEARCH;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The early lane's delay equals the cycles counted since its marker when the late marker lands.
  always_comb begin
    d0_d    = d0_q;
    d1_d    = d1_q;
    cnt_d   = cnt_q;
    skew_d  = skew_q;
    early_d = early_q;
    err_d   = 1'b0;
    if (!enable_deskew) begin
      d0_d    = '0;
      d1_d    = '0;
      cnt_d   = '0;
      skew_d  = '0;
      early_d = 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (mark0 && mark1) begin
            d0_d    = '0;
            d1_d    = '0;
            cnt_d   = '0;
            skew_d  = '0;
            early_d = 1'b0;
          end else if (mark0 || mark1) begin
            cnt_d = 4'd1;
          end
        end
        WAIT0: begin
          if (mark1) begin
            d0_d    = cnt_q;
            d1_d    = '0;
            skew_d  = cnt_q;
            early_d = 1'b0;
          end else if (mark0) begin
            cnt_d = 4'd1;
          end else if (overflow) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc[3:0];
          end
        end
        WAIT1: begin
          if (mark0) begin
            d0_d    = '0;
            d1_d    = cnt_q;
            skew_d  = cnt_q;
            early_d = 1'b1;
          end else if (mark1) begin
            cnt_d = 4'd1;
          end else if (overflow) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc[3:0];
          end
        end
        LOCKED: begin
`ifdef LANE_DESKEW_RELOCK_EN
          if ((tap0[d0_q] == SYNC_BYTE) != (tap1[d1_q] == SYNC_BYTE)) begin
            err_d = 1'b1;
            cnt_d = '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign valid_d = (state_d == LOCKED);

  assign lane_0_out  = out0_q;
  assign lane_1_out  = out1_q;
  assign lane_valid  = valid_q;
  assign deskew_lock = valid_q;
  assign deskew_err  = err_q;
  assign skew_val    = skew_q;
  assign early_lane  = early_q;

endmodule

// File: tb/tb_lane_deskew.sv
// tb_lane_deskew: table-driven scoreboard bench for lane_deskew (default MAX_SKEW=8, SYNC_BYTE=8'h5A).
module tb_lane_deskew;

   typedef struct {
      string      name;
      logic       rst;
      logic       en;
      logic [7:0] l0;
      logic [7:0] l1;
      logic       ev;
      logic       eerr;
      logic       chkData;
      logic [7:0] eo0;
      logic [7:0] eo1;
      logic       chkMeta;
      logic [3:0] eskew;
      logic       eearly;
   } vec_t;

   logic       enc_clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable_deskew = 1'b0;
   logic [7:0] lane_0_rx = 8'h00;
   logic [7:0] lane_1_rx = 8'h00;
   logic [7:0] lane_0_out, lane_1_out;
   logic       lane_valid, deskew_lock, deskew_err, early_lane;
   logic [3:0] skew_val;

   int   assertCount = 0;
   int   failCount = 0;
   vec_t vecs[$];
   vec_t sbQueue[$];

   lane_deskew dut (
      .enc_clk(enc_clk),
      .rst(rst),
      .enable_deskew(enable_deskew),
      .lane_0_rx(lane_0_rx),
      .lane_1_rx(lane_1_rx),
      .lane_0_out(lane_0_out),
      .lane_1_out(lane_1_out),
      .lane_valid(lane_valid),
      .deskew_lock(deskew_lock),
      .deskew_err(deskew_err),
      .skew_val(skew_val),
      .early_lane(early_lane)
   );

   always #5 enc_clk = ~enc_clk;

   function automatic vec_t mk(string nm, logic r, logic e, logic [7:0] a, logic [7:0] b,
                               logic v, logic er, logic cd, logic [7:0] o0, logic [7:0] o1,
                               logic cm, logic [3:0] sk, logic el);
      vec_t t;
      t.name = nm; t.rst = r; t.en = e; t.l0 = a; t.l1 = b;
      t.ev = v; t.eerr = er; t.chkData = cd; t.eo0 = o0; t.eo1 = o1;
      t.chkMeta = cm; t.eskew = sk; t.eearly = el;
      return t;
   endfunction

   task automatic check1(string nm, string what, logic [7:0] act, logic [7:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s.%s: got %0h expected %0h", nm, what, act, exp);
      end
   endtask

   task automatic applyStimulus(vec_t v);
      rst = v.rst;
      enable_deskew = v.en;
      lane_0_rx = v.l0;
      lane_1_rx = v.l1;
      sbQueue.push_back(v);
   endtask

   task automatic checkOutput();
      vec_t e;
      assertCount++;
      if (sbQueue.size() == 0) begin
         failCount++;
         $display("[TB] FAIL scoreboard: got empty queue expected one entry");
         return;
      end
      e = sbQueue.pop_front();
      check1(e.name, "lane_valid", {7'd0, lane_valid}, {7'd0, e.ev});
      check1(e.name, "deskew_lock", {7'd0, deskew_lock}, {7'd0, e.ev});
      check1(e.name, "deskew_err", {7'd0, deskew_err}, {7'd0, e.eerr});
      if (e.chkData) begin
         check1(e.name, "lane_0_out", lane_0_out, e.eo0);
         check1(e.name, "lane_1_out", lane_1_out, e.eo1);
      end
      if (e.chkMeta) begin
         check1(e.name, "skew_val", {4'd0, skew_val}, {4'd0, e.eskew});
         if (e.eskew != 4'd0) check1(e.name, "early_lane", {7'd0, early_lane}, {7'd0, e.eearly});
      end
   endtask

   task automatic runRow(vec_t v);
      applyStimulus(v);
      @(posedge enc_clk);
      #1;
      checkOutput();
   endtask

   initial begin
      // Table: reset, zero skew, lane 0 early by 3, overflow then skew-8 lock, restart.
      vecs.push_back(mk("rst0",      1, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));
      vecs.push_back(mk("rst1",      1, 1, 8'h5A, 8'h5A, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));
      vecs.push_back(mk("z_search",  0, 1, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));
      vecs.push_back(mk("z_lock",    0, 1, 8'h5A, 8'h5A, 1, 0, 1, 8'h5A, 8'h5A, 1, 0, 0));
      vecs.push_back(mk("z_d1",      0, 1, 8'h01, 8'h01, 1, 0, 1, 8'h01, 8'h01, 1, 0, 0));
      vecs.push_back(mk("z_d2",      0, 1, 8'h02, 8'h02, 1, 0, 1, 8'h02, 8'h02, 1, 0, 0));
      vecs.push_back(mk("z_drop",    0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));
      vecs.push_back(mk("s3_search", 0, 1, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));
      vecs.push_back(mk("s3_m0",     0, 1, 8'h5A, 8'h11, 0, 0, 1, 8'h5A, 8'h11, 1, 0, 0));
      vecs.push_back(mk("s3_w1",     0, 1, 8'hA1, 8'h12, 0, 0, 1, 8'hA1, 8'h12, 1, 0, 0));
      vecs.push_back(mk("s3_w2",     0, 1, 8'hA2, 8'h13, 0, 0, 1, 8'hA2, 8'h13, 1, 0, 0));
      vecs.push_back(mk("s3_lock",   0, 1, 8'hA3, 8'h5A, 1, 0, 1, 8'h5A, 8'h5A, 1, 3, 0));
      vecs.push_back(mk("s3_d1",     0, 1, 8'hA4, 8'hB1, 1, 0, 1, 8'hA1, 8'hB1, 1, 3, 0));
      vecs.push_back(mk("s3_d2",     0, 1, 8'hA5, 8'hB2, 1, 0, 1, 8'hA2, 8'hB2, 1, 3, 0));
      vecs.push_back(mk("s3_drop",   0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));
      vecs.push_back(mk("ov_search", 0, 1, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));
      vecs.push_back(mk("ov_m1",     0, 1, 8'h00, 8'h5A, 0, 0, 1, 8'h00, 8'h5A, 1, 0, 0));
      for (int k = 0; k < 7; k++)
         vecs.push_back(mk("ov_wait", 0, 1, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));
      vecs.push_back(mk("ov_err",    0, 1, 8'h00, 8'h00, 0, 1, 1, 8'h00, 8'h00, 1, 0, 0));
      vecs.push_back(mk("ov_post",   0, 1, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));
      vecs.push_back(mk("ov8_m1",    0, 1, 8'hC0, 8'h5A, 0, 0, 1, 8'hC0, 8'h5A, 1, 0, 0));
      for (int k = 1; k < 8; k++)
         vecs.push_back(mk("ov8_wait", 0, 1, 8'h00, 8'(8'hD0 + k), 0, 0, 1, 8'h00, 8'(8'hD0 + k), 1, 0, 0));
      vecs.push_back(mk("ov8_lock",  0, 1, 8'h5A, 8'hD8, 1, 0, 1, 8'h5A, 8'h5A, 1, 8, 1));
      vecs.push_back(mk("ov8_d1",    0, 1, 8'hE1, 8'hD9, 1, 0, 1, 8'hE1, 8'hD1, 1, 8, 1));
      vecs.push_back(mk("ov8_drop",  0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));
      vecs.push_back(mk("rs_search", 0, 1, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));
      vecs.push_back(mk("rs_m0a",    0, 1, 8'h5A, 8'h00, 0, 0, 1, 8'h5A, 8'h00, 1, 0, 0));
      vecs.push_back(mk("rs_w",      0, 1, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));
      vecs.push_back(mk("rs_m0b",    0, 1, 8'h5A, 8'h00, 0, 0, 1, 8'h5A, 8'h00, 1, 0, 0));
      vecs.push_back(mk("rs_lock",   0, 1, 8'hF1, 8'h5A, 1, 0, 1, 8'h5A, 8'h5A, 1, 1, 0));
      vecs.push_back(mk("rs_d1",     0, 1, 8'hF2, 8'hF3, 1, 0, 1, 8'hF1, 8'hF3, 1, 1, 0));
      vecs.push_back(mk("rs_drop",   0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));

      for (int i = 0; i < vecs.size(); i++) runRow(vecs[i]);

      // Reset during WAIT0: a marker pair right after reset must not lock from a stale WAIT0.
      runRow(mk("wr_search", 0, 1, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));
      runRow(mk("wr_m0",     0, 1, 8'h5A, 8'h00, 0, 0, 1, 8'h5A, 8'h00, 1, 0, 0));
      runRow(mk("wr_rst",    1, 1, 8'h5A, 8'h5A, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));
      runRow(mk("wr_idle",   0, 1, 8'h5A, 8'h5A, 0, 0, 1, 8'h5A, 8'h5A, 1, 0, 0));
      runRow(mk("wr_lock",   0, 1, 8'h5A, 8'h5A, 1, 0, 1, 8'h5A, 8'h5A, 1, 0, 0));
      runRow(mk("wr_drop",   0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));

      // Lock at skew 2, then a lone lane-1 marker, then a correctly skewed pair.
      runRow(mk("rl_search", 0, 1, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));
      runRow(mk("rl_m0",     0, 1, 8'h5A, 8'h00, 0, 0, 1, 8'h5A, 8'h00, 1, 0, 0));
      runRow(mk("rl_w",      0, 1, 8'h01, 8'h00, 0, 0, 1, 8'h01, 8'h00, 1, 0, 0));
      runRow(mk("rl_lock",   0, 1, 8'h02, 8'h5A, 1, 0, 1, 8'h5A, 8'h5A, 1, 2, 0));
      runRow(mk("rl_d1",     0, 1, 8'h03, 8'h10, 1, 0, 1, 8'h01, 8'h10, 1, 2, 0));
`ifdef LANE_DESKEW_RELOCK_EN
      runRow(mk("rl_lone",   0, 1, 8'h04, 8'h5A, 0, 1, 1, 8'h02, 8'h5A, 0, 0, 0));
      runRow(mk("rl_m0b",    0, 1, 8'h5A, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
      runRow(mk("rl_w2",     0, 1, 8'h06, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
`else
      runRow(mk("rl_lone",   0, 1, 8'h04, 8'h5A, 1, 0, 1, 8'h02, 8'h5A, 1, 2, 0));
      runRow(mk("rl_m0b",    0, 1, 8'h5A, 8'h00, 1, 0, 1, 8'h03, 8'h00, 1, 2, 0));
      runRow(mk("rl_w2",     0, 1, 8'h06, 8'h00, 1, 0, 1, 8'h04, 8'h00, 1, 2, 0));
`endif
      runRow(mk("rl_relock", 0, 1, 8'h07, 8'h5A, 1, 0, 1, 8'h5A, 8'h5A, 1, 2, 0));
      runRow(mk("rl_drop",   0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
